// File: rtl/mul_div_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Optional zero-operand multiply shortcut is enabled by macro MUL_DIV_ZERO_SKIP_EN.
package mul_div_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [DEF_WIDTH-1:0] DZ_QUOT = '1;

   typedef enum logic [1:0] {
      OP_MULU = 2'd0,
      OP_DIVU = 2'd1,
      OP_MUL  = 2'd2,
      OP_DIV  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/mul_div_sign.sv
// Combinational conditional two's-complement negate, used for |operand| on
// capture and for applying result signs on writeback.
module mul_div_sign #(
   parameter int N = 32
) (
   input  logic [N-1:0] val,
   input  logic         neg,
   output logic [N-1:0] result
);

   assign result = neg ? (~val + N'(1)) : val;

endmodule

// File: rtl/mul_div_seq.sv
// Radix-2 sequential multiply/divide unit owning HI/LO.
// Define MUL_DIV_ZERO_SKIP_EN to short-cut multiplies with a zero operand.
module mul_div_seq
   import mul_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   logic               is_div;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   b;
   logic               neg_res;
   logic               neg_rem;
   logic               dz_pend;

   logic               op_signed;
   logic               sx;
   logic               sy;
   logic [WIDTH-1:0]   abs_x;
   logic [WIDTH-1:0]   abs_y;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic               ge;
   logic [WIDTH-1:0]   rem_next;

   assign op_signed = op[1];
   assign sx = op_signed & x[WIDTH-1];
   assign sy = op_signed & y[WIDTH-1];

   mul_div_sign #(.N(WIDTH)) u_abs_x (.val(x), .neg(sx), .result(abs_x));
   mul_div_sign #(.N(WIDTH)) u_abs_y (.val(y), .neg(sy), .result(abs_y));

   mul_div_sign #(.N(2*WIDTH)) u_fix_prod (.val(acc), .neg(neg_res), .result(prod_fix));
   mul_div_sign #(.N(WIDTH)) u_fix_quot (.val(acc[WIDTH-1:0]), .neg(neg_res), .result(quot_fix));
   mul_div_sign #(.N(WIDTH)) u_fix_rem (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem), .result(rem_fix));

   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide:   acc = {remainder, dividend bits shifting into quotient}.
   assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b : '0)};
   assign shifted  = acc[2*WIDTH-1:WIDTH-1];
   assign ge       = shifted >= {1'b0, b};
   assign rem_next = ge ? (shifted[WIDTH-1:0] - b) : shifted[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         is_div   <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         b        <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         dz_pend  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     is_div   <= op[0];
                     cnt      <= '0;
                     div_zero <= 1'b0;
                     busy     <= 1'b1;
                     neg_res  <= sx ^ sy;
                     neg_rem  <= sx;
                     dz_pend  <= 1'b0;
                     if (op[0]) begin
                        acc <= {{WIDTH{1'b0}}, abs_x};
                        b   <= abs_y;
                     end else begin
                        acc <= {{WIDTH{1'b0}}, abs_y};
                        b   <= abs_x;
                     end
                     if (op[0] && y == '0) begin
                        // Raw dividend is parked in acc so it can be returned in hi.
                        acc     <= {{WIDTH{1'b0}}, x};
                        dz_pend <= 1'b1;
                        state   <= S_FIX;
                     end
`ifdef MUL_DIV_ZERO_SKIP_EN
                     else if (!op[0] && (x == '0 || y == '0)) begin
                        acc   <= '0;
                        state <= S_FIX;
                     end
`endif
                     else begin
                        state <= S_RUN;
                     end
                  end
               end
               S_RUN: begin
                  if (is_div) begin
                     acc <= {rem_next, acc[WIDTH-2:0], ge};
                  end else begin
                     acc <= {sum, acc[WIDTH-1:1]};
                  end
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     state <= S_FIX;
                  end
               end
               S_FIX: begin
                  if (dz_pend) begin
                     lo       <= {WIDTH{1'b1}};
                     hi       <= acc[WIDTH-1:0];
                     div_zero <= 1'b1;
                  end else if (is_div) begin
                     lo <= quot_fix;
                     hi <= rem_fix;
                  end else begin
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                     lo <= prod_fix[WIDTH-1:0];
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
